// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//
// Arbitrates a fetch port (inst_*) and a load/store port (data_*) onto one
// shared memory request/response interface. Only one memory transaction is
// in flight at a time. The granted port's request fields are latched at
// grant time, and the memory side is driven from those latched copies.
//
// Parameter
//   DATA_PRIO   1: data port wins simultaneous requests
//               0: simultaneous requests alternate (round-robin)
//
// Ports
//   clk, resetn                  clock, asynchronous active-low reset
//   inst_req/inst_addr           fetch request (read only)
//   inst_addr_ok/inst_data_ok    fetch accept / response pulses
//   inst_rdata                   fetch data (held until the next fetch response)
//   data_req/wr/wstrb/addr/wdata load/store request
//   data_addr_ok/data_data_ok    load/store accept / response pulses
//   data_rdata                   load data (held; stores leave it unchanged)
//   mem_req/wr/wstrb/addr/wdata  shared memory request
//   mem_addr_ok/mem_data_ok      memory accept / response pulses
//   mem_rdata                    memory response data
//   stallreq                     pipeline stall request
// ---------------------------------------------------------------------------
module sram_arbiter #(
   parameter int DATA_PRIO = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata,
   output logic        stallreq
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      I_ADDR = 3'd1,
      I_DATA = 3'd2,
      D_ADDR = 3'd3,
      D_DATA = 3'd4
   } state_t;

   localparam logic PRIO_DATA = (DATA_PRIO != 0);

   state_t      state_reg;
   state_t      state_next;
   logic        last_grant_reg;      // 1 = last grant went to the data port
   logic        lat_wr_reg;
   logic [3:0]  lat_wstrb_reg;
   logic [31:0] lat_addr_reg;
   logic [31:0] lat_wdata_reg;
   logic [31:0] inst_rdata_reg;
   logic [31:0] data_rdata_reg;

   logic        grant;
   logic        pick_data;
   logic        pending;
   logic        in_addr;
   logic        in_data;
   logic        done;
   logic        data_load_done;

   assign pending = inst_req | data_req;
   assign in_addr = (state_reg == I_ADDR) || (state_reg == D_ADDR);
   assign in_data = (state_reg == I_DATA) || (state_reg == D_DATA);
   assign done    = in_data & mem_data_ok;

   // Data wins if it is the only requester, if it has fixed priority, or if
   // the previous grant went to the fetch port (round-robin tie break).
   assign pick_data = data_req & (~inst_req | PRIO_DATA | ~last_grant_reg);

   always_comb begin
      state_next = state_reg;
      grant      = 1'b0;
      case (state_reg)
         IDLE:   grant = pending;
         I_ADDR: if (mem_addr_ok) state_next = I_DATA;
         D_ADDR: if (mem_addr_ok) state_next = D_DATA;
         I_DATA, D_DATA: begin
            // Re-arbitrate in the response cycle so a waiting port does not
            // pay an IDLE bubble.
            if (mem_data_ok) begin
               if (pending) grant = 1'b1;
               else         state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      if (grant) state_next = pick_data ? D_ADDR : I_ADDR;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg      <= IDLE;
         last_grant_reg <= 1'b0;
         lat_wr_reg     <= 1'b0;
         lat_wstrb_reg  <= 4'h0;
         lat_addr_reg   <= 32'h0;
         lat_wdata_reg  <= 32'h0;
         inst_rdata_reg <= 32'h0;
         data_rdata_reg <= 32'h0;
      end else begin
         state_reg <= state_next;
         if (grant) begin
            // Fetches are always reads: write fields are forced to zero.
            last_grant_reg <= pick_data;
            lat_wr_reg     <= pick_data & data_wr;
            lat_wstrb_reg  <= pick_data ? data_wstrb : 4'h0;
            lat_addr_reg   <= pick_data ? data_addr  : inst_addr;
            lat_wdata_reg  <= pick_data ? data_wdata : 32'h0;
         end
         if (state_reg == I_DATA && mem_data_ok) inst_rdata_reg <= mem_rdata;
         if (data_load_done)                    data_rdata_reg <= mem_rdata;
      end
   end

   assign mem_req   = in_addr;
   assign mem_wr    = lat_wr_reg;
   assign mem_wstrb = lat_wstrb_reg;
   assign mem_addr  = lat_addr_reg;
   assign mem_wdata = lat_wdata_reg;

   assign inst_addr_ok = (state_reg == I_ADDR) & mem_addr_ok;
   assign data_addr_ok = (state_reg == D_ADDR) & mem_addr_ok;
   assign inst_data_ok = (state_reg == I_DATA) & mem_data_ok;
   assign data_data_ok = (state_reg == D_DATA) & mem_data_ok;

   // Store completions carry no read data, so data_rdata keeps its old value.
   assign data_load_done = data_data_ok & ~lat_wr_reg;

   // Response data is forwarded in its own cycle and held afterwards.
   assign inst_rdata = inst_data_ok   ? mem_rdata : inst_rdata_reg;
   assign data_rdata = data_load_done ? mem_rdata : data_rdata_reg;

   // Stall drops in the response cycle when nothing else is queued; held low
   // while reset is asserted so every output reads zero during reset.
   assign stallreq = resetn & (pending | (state_reg != IDLE)) & ~(done & ~pending);

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

   logic        clk;
   logic        resetn;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        data_req;
   logic        data_wr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        mem_addr_ok;
   logic        mem_data_ok;
   logic [31:0] mem_rdata;

   // fixed-priority instance (dp) and round-robin instance (rr), same stimulus
   logic        dp_inst_addr_ok, dp_inst_data_ok, dp_data_addr_ok, dp_data_data_ok;
   logic [31:0] dp_inst_rdata, dp_data_rdata, dp_mem_addr, dp_mem_wdata;
   logic        dp_mem_req, dp_mem_wr, dp_stallreq;
   logic [3:0]  dp_mem_wstrb;
   logic        rr_inst_addr_ok, rr_inst_data_ok, rr_data_addr_ok, rr_data_data_ok;
   logic [31:0] rr_inst_rdata, rr_data_rdata, rr_mem_addr, rr_mem_wdata;
   logic        rr_mem_req, rr_mem_wr, rr_stallreq;
   logic [3:0]  rr_mem_wstrb;

   sram_arbiter #(.DATA_PRIO(1)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_addr_ok(dp_inst_addr_ok), .inst_data_ok(dp_inst_data_ok), .inst_rdata(dp_inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(dp_data_addr_ok), .data_data_ok(dp_data_data_ok), .data_rdata(dp_data_rdata),
      .mem_req(dp_mem_req), .mem_wr(dp_mem_wr), .mem_wstrb(dp_mem_wstrb),
      .mem_addr(dp_mem_addr), .mem_wdata(dp_mem_wdata),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
      .stallreq(dp_stallreq)
   );

   sram_arbiter #(.DATA_PRIO(0)) dut_rr (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_addr_ok(rr_inst_addr_ok), .inst_data_ok(rr_inst_data_ok), .inst_rdata(rr_inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(rr_data_addr_ok), .data_data_ok(rr_data_data_ok), .data_rdata(rr_data_rdata),
      .mem_req(rr_mem_req), .mem_wr(rr_mem_wr), .mem_wstrb(rr_mem_wstrb),
      .mem_addr(rr_mem_addr), .mem_wdata(rr_mem_wdata),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
      .stallreq(rr_stallreq)
   );

   // output vector order: inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok,
   // data_data_ok, data_rdata, mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata, stallreq
   logic [138:0] act_dp, act_rr;
   assign act_dp = {dp_inst_addr_ok, dp_inst_data_ok, dp_inst_rdata, dp_data_addr_ok, dp_data_data_ok,
                    dp_data_rdata, dp_mem_req, dp_mem_wr, dp_mem_wstrb, dp_mem_addr, dp_mem_wdata, dp_stallreq};
   assign act_rr = {rr_inst_addr_ok, rr_inst_data_ok, rr_inst_rdata, rr_data_addr_ok, rr_data_data_ok,
                    rr_data_rdata, rr_mem_req, rr_mem_wr, rr_mem_wstrb, rr_mem_addr, rr_mem_wdata, rr_stallreq};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ------------------------------------------------------------------
   // Reference model: one outstanding transaction described by flags
   // ------------------------------------------------------------------
   typedef struct {
      bit        busy;     // a transaction owns the memory
      bit        own_d;    // owner is the data port
      bit        acc;      // memory has accepted the address
      bit        last_d;   // most recent grant went to data
      bit        wr;
      bit [3:0]  wstrb;
      bit [31:0] addr;
      bit [31:0] wdata;
      bit [31:0] rd_i;
      bit [31:0] rd_d;
   } mdl_t;

   mdl_t m [2];   // index = DATA_PRIO of the instance

   function automatic mdl_t m_reset();
      mdl_t r;
      r.busy = 0; r.own_d = 0; r.acc = 0; r.last_d = 0; r.wr = 0;
      r.wstrb = 0; r.addr = 0; r.wdata = 0; r.rd_i = 0; r.rd_d = 0;
      return r;
   endfunction

   function automatic logic [138:0] m_out(input mdl_t s);
      logic ap, dn, pend, iao, dao, ido, ddo, stall;
      logic [31:0] ird, drd;
      if (!resetn) return '0;
      ap    = s.busy & ~s.acc;
      dn    = s.busy & s.acc & mem_data_ok;
      pend  = inst_req | data_req;
      iao   = ap & ~s.own_d & mem_addr_ok;
      dao   = ap & s.own_d & mem_addr_ok;
      ido   = dn & ~s.own_d;
      ddo   = dn & s.own_d;
      ird   = ido ? mem_rdata : s.rd_i;
      drd   = (ddo && !s.wr) ? mem_rdata : s.rd_d;
      stall = (pend | s.busy) & ~(dn & ~pend);
      return {iao, ido, ird, dao, ddo, drd, ap, s.wr, s.wstrb, s.addr, s.wdata, stall};
   endfunction

   function automatic mdl_t m_next(input mdl_t s, input bit prio);
      mdl_t n;
      bit dn, win_d;
      if (!resetn) return m_reset();
      n  = s;
      dn = s.busy & s.acc & mem_data_ok;
      if (dn) begin
         if (!s.own_d)    n.rd_i = mem_rdata;
         else if (!s.wr)  n.rd_d = mem_rdata;
      end
      if ((!s.busy || dn) && (inst_req || data_req)) begin
         win_d    = data_req && (!inst_req || prio || !s.last_d);
         n.busy   = 1; n.acc = 0; n.own_d = win_d; n.last_d = win_d;
         n.wr     = win_d ? data_wr : 1'b0;
         n.wstrb  = win_d ? data_wstrb : 4'h0;
         n.addr   = win_d ? data_addr : inst_addr;
         n.wdata  = win_d ? data_wdata : 32'h0;
      end else if (dn) begin
         n.busy = 0;
      end else if (s.busy && !s.acc && mem_addr_ok) begin
         n.acc = 1;
      end
      return n;
   endfunction

   // ------------------------------------------------------------------
   // Directed vector table (expectations for the DATA_PRIO=1 instance)
   // ------------------------------------------------------------------
   typedef struct packed {
      logic        rstn;
      logic        ireq;
      logic [31:0] iaddr;
      logic        dreq;
      logic        dwr;
      logic [3:0]  dwstrb;
      logic [31:0] daddr;
      logic [31:0] dwdata;
      logic        maok;
      logic        mdok;
      logic [31:0] mrdata;
   } in_t;

   typedef struct {
      in_t          in;
      logic [138:0] exp;
   } vec_t;

   function automatic in_t mk_in(input logic rstn, input logic ireq, input logic [31:0] iaddr,
                                 input logic dreq, input logic dwr, input logic [3:0] dwstrb,
                                 input logic [31:0] daddr, input logic [31:0] dwdata,
                                 input logic maok, input logic mdok, input logic [31:0] mrdata);
      return {rstn, ireq, iaddr, dreq, dwr, dwstrb, daddr, dwdata, maok, mdok, mrdata};
   endfunction

   function automatic logic [138:0] mk_exp(input logic iao, input logic ido, input logic [31:0] ird,
                                           input logic dao, input logic ddo, input logic [31:0] drd,
                                           input logic mreq, input logic mwr, input logic [3:0] mwstrb,
                                           input logic [31:0] maddr, input logic [31:0] mwdata, input logic stall);
      return {iao, ido, ird, dao, ddo, drd, mreq, mwr, mwstrb, maddr, mwdata, stall};
   endfunction

   task automatic apply_in(input in_t v);
      resetn      = v.rstn;
      inst_req    = v.ireq;
      inst_addr   = v.iaddr;
      data_req    = v.dreq;
      data_wr     = v.dwr;
      data_wstrb  = v.dwstrb;
      data_addr   = v.daddr;
      data_wdata  = v.dwdata;
      mem_addr_ok = v.maok;
      mem_data_ok = v.mdok;
      mem_rdata   = v.mrdata;
   endtask

   // per-cycle hooks
   bit           tbl_on = 0;
   int           tbl_idx = 0;
   logic [138:0] tbl_exp = '0;
   bit           rec = 0;
   bit           q_dp[$];
   bit           q_rr[$];
   int           cyc = 0;

   task automatic tick();
      logic [138:0] e;
      mdl_t nx [2];
      @(negedge clk);
      if (tbl_on) begin
         checks++;
         if (act_dp !== tbl_exp) begin
            errors++;
            $display("FAIL vec[%0d]: got %h expected %h", tbl_idx, act_dp, tbl_exp);
         end else
            $display("vec[%0d] ok: outputs %h", tbl_idx, act_dp);
      end
      for (int k = 0; k < 2; k++) begin
         e = m_out(m[k]);
         checks++;
         if (((k == 1) ? act_dp : act_rr) !== e) begin
            errors++;
            $display("FAIL model prio=%0d cycle %0d: got %h expected %h", k, cyc,
                     (k == 1) ? act_dp : act_rr, e);
         end
         nx[k] = m_next(m[k], k[0]);
      end
      if (rec) begin
         if (dp_data_addr_ok) q_dp.push_back(1'b1);
         if (dp_inst_addr_ok) q_dp.push_back(1'b0);
         if (rr_data_addr_ok) q_rr.push_back(1'b1);
         if (rr_inst_addr_ok) q_rr.push_back(1'b0);
      end
      @(posedge clk);
      m[0] = nx[0];
      m[1] = nx[1];
      cyc++;
      #1;
   endtask

   localparam logic [31:0] IA  = 32'hBFC0_0000;
   localparam logic [31:0] DA  = 32'h8000_1000;
   localparam logic [31:0] DA2 = 32'h8000_2000;
   localparam logic [31:0] WD  = 32'hDEAD_BEEF;
   localparam logic [31:0] R1  = 32'h3C08_0001;
   localparam logic [31:0] R2  = 32'h1234_5678;
   localparam logic [31:0] R3  = 32'hAAAA_5555;
   localparam logic [31:0] R4  = 32'hCAFE_F00D;
   localparam logic [31:0] R5  = 32'h0123_4567;
   localparam logic [31:0] Z   = 32'h0;

   vec_t tbl [21];

   initial begin
      // fetch: accept on cycle 1, response on cycle 3
      tbl[0]  = '{mk_in(1'b1,1'b1,IA,1'b0,1'b0,4'h0,Z,Z,1'b0,1'b0,Z),  mk_exp(1'b0,1'b0,Z,1'b0,1'b0,Z,1'b0,1'b0,4'h0,Z,Z,1'b1)};
      tbl[1]  = '{mk_in(1'b1,1'b1,IA,1'b0,1'b0,4'h0,Z,Z,1'b1,1'b0,Z),  mk_exp(1'b1,1'b0,Z,1'b0,1'b0,Z,1'b1,1'b0,4'h0,IA,Z,1'b1)};
      tbl[2]  = '{mk_in(1'b1,1'b0,IA,1'b0,1'b0,4'h0,Z,Z,1'b0,1'b0,Z),  mk_exp(1'b0,1'b0,Z,1'b0,1'b0,Z,1'b0,1'b0,4'h0,IA,Z,1'b1)};
      tbl[3]  = '{mk_in(1'b1,1'b0,Z,1'b0,1'b0,4'h0,Z,Z,1'b0,1'b1,R1),  mk_exp(1'b0,1'b1,R1,1'b0,1'b0,Z,1'b0,1'b0,4'h0,IA,Z,1'b0)};
      tbl[4]  = '{mk_in(1'b1,1'b0,Z,1'b0,1'b0,4'h0,Z,Z,1'b0,1'b0,Z),   mk_exp(1'b0,1'b0,R1,1'b0,1'b0,Z,1'b0,1'b0,4'h0,IA,Z,1'b0)};
      // store: data_rdata must stay unchanged on completion
      tbl[5]  = '{mk_in(1'b1,1'b0,Z,1'b1,1'b1,4'hF,DA,WD,1'b0,1'b0,Z), mk_exp(1'b0,1'b0,R1,1'b0,1'b0,Z,1'b0,1'b0,4'h0,IA,Z,1'b1)};
      tbl[6]  = '{mk_in(1'b1,1'b0,Z,1'b1,1'b1,4'hF,DA,WD,1'b1,1'b0,Z), mk_exp(1'b0,1'b0,R1,1'b1,1'b0,Z,1'b1,1'b1,4'hF,DA,WD,1'b1)};
      tbl[7]  = '{mk_in(1'b1,1'b0,Z,1'b0,1'b0,4'h0,Z,Z,1'b0,1'b0,Z),   mk_exp(1'b0,1'b0,R1,1'b0,1'b0,Z,1'b0,1'b1,4'hF,DA,WD,1'b1)};
      tbl[8]  = '{mk_in(1'b1,1'b0,Z,1'b0,1'b0,4'h0,Z,Z,1'b0,1'b1,R2),  mk_exp(1'b0,1'b0,R1,1'b0,1'b1,Z,1'b0,1'b1,4'hF,DA,WD,1'b0)};
      // load reaching D_DATA, then a one-cycle reset and a late response
      tbl[9]  = '{mk_in(1'b1,1'b0,Z,1'b1,1'b0,4'h0,DA2,Z,1'b0,1'b0,Z), mk_exp(1'b0,1'b0,R1,1'b0,1'b0,Z,1'b0,1'b1,4'hF,DA,WD,1'b1)};
      tbl[10] = '{mk_in(1'b1,1'b0,Z,1'b1,1'b0,4'h0,DA2,Z,1'b1,1'b0,Z), mk_exp(1'b0,1'b0,R1,1'b1,1'b0,Z,1'b1,1'b0,4'h0,DA2,Z,1'b1)};
      tbl[11] = '{mk_in(1'b1,1'b0,Z,1'b0,1'b0,4'h0,Z,Z,1'b0,1'b0,Z),   mk_exp(1'b0,1'b0,R1,1'b0,1'b0,Z,1'b0,1'b0,4'h0,DA2,Z,1'b1)};
      tbl[12] = '{mk_in(1'b0,1'b0,Z,1'b0,1'b0,4'h0,Z,Z,1'b0,1'b0,Z),   '0};
      tbl[13] = '{mk_in(1'b1,1'b0,Z,1'b0,1'b0,4'h0,Z,Z,1'b0,1'b1,R3),  '0};
      // simultaneous requests: data first, fetch granted in the data response cycle
      tbl[14] = '{mk_in(1'b1,1'b1,IA,1'b1,1'b0,4'h0,DA,Z,1'b0,1'b0,Z), mk_exp(1'b0,1'b0,Z,1'b0,1'b0,Z,1'b0,1'b0,4'h0,Z,Z,1'b1)};
      tbl[15] = '{mk_in(1'b1,1'b1,IA,1'b1,1'b0,4'h0,DA,Z,1'b1,1'b0,Z), mk_exp(1'b0,1'b0,Z,1'b1,1'b0,Z,1'b1,1'b0,4'h0,DA,Z,1'b1)};
      tbl[16] = '{mk_in(1'b1,1'b1,IA,1'b0,1'b0,4'h0,Z,Z,1'b0,1'b0,Z),  mk_exp(1'b0,1'b0,Z,1'b0,1'b0,Z,1'b0,1'b0,4'h0,DA,Z,1'b1)};
      tbl[17] = '{mk_in(1'b1,1'b1,IA,1'b0,1'b0,4'h0,Z,Z,1'b0,1'b1,R4), mk_exp(1'b0,1'b0,Z,1'b0,1'b1,R4,1'b0,1'b0,4'h0,DA,Z,1'b1)};
      tbl[18] = '{mk_in(1'b1,1'b1,IA,1'b0,1'b0,4'h0,Z,Z,1'b0,1'b0,Z),  mk_exp(1'b0,1'b0,Z,1'b0,1'b0,R4,1'b1,1'b0,4'h0,IA,Z,1'b1)};
      tbl[19] = '{mk_in(1'b1,1'b1,IA,1'b0,1'b0,4'h0,Z,Z,1'b1,1'b0,Z),  mk_exp(1'b1,1'b0,Z,1'b0,1'b0,R4,1'b1,1'b0,4'h0,IA,Z,1'b1)};
      tbl[20] = '{mk_in(1'b1,1'b0,Z,1'b0,1'b0,4'h0,Z,Z,1'b0,1'b1,R5),  mk_exp(1'b0,1'b1,R5,1'b0,1'b0,R4,1'b0,1'b0,4'h0,IA,Z,1'b0)};

      m[0] = m_reset();
      m[1] = m_reset();
      apply_in(mk_in(1'b0,1'b0,Z,1'b0,1'b0,4'h0,Z,Z,1'b0,1'b0,Z));
      repeat (3) tick();

      // reset state
      checks++;
      if (act_dp !== '0) begin errors++; $display("FAIL reset_dp: got %h expected 0", act_dp); end
      else $display("reset_dp ok");
      checks++;
      if (act_rr !== '0) begin errors++; $display("FAIL reset_rr: got %h expected 0", act_rr); end
      else $display("reset_rr ok");

      resetn = 1'b1;
      tick();

      tbl_on = 1;
      for (int i = 0; i < 21; i++) begin
         tbl_idx = i;
         tbl_exp = tbl[i].exp;
         apply_in(tbl[i].in);
         tick();
      end
      tbl_on = 0;

      // grant order with both requests held continuously
      apply_in(mk_in(1'b0,1'b0,Z,1'b0,1'b0,4'h0,Z,Z,1'b0,1'b0,Z));
      tick();
      apply_in(mk_in(1'b1,1'b1,IA,1'b1,1'b0,4'h0,DA,Z,1'b1,1'b1,R2));
      rec = 1;
      for (int c = 0; c < 40 && (q_dp.size() < 4 || q_rr.size() < 4); c++) tick();
      rec = 0;
      checks++;
      if (q_dp.size() < 4 || q_rr.size() < 4) begin
         errors++;
         $display("FAIL grant_order_timeout: got %0d/%0d grants required 4/4", q_dp.size(), q_rr.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (q_rr[i] != (i % 2 == 0)) begin
               errors++;
               $display("FAIL rr_grant[%0d]: got data=%0d required data=%0d", i, q_rr[i], (i % 2 == 0));
            end else
               $display("rr_grant[%0d] ok: data=%0d", i, q_rr[i]);
            checks++;
            if (q_dp[i] != 1'b1) begin
               errors++;
               $display("FAIL dp_grant[%0d]: got data=%0d required data=1", i, q_dp[i]);
            end else
               $display("dp_grant[%0d] ok: data=%0d", i, q_dp[i]);
         end
      end

      // randomized traffic against the reference model
      for (int i = 0; i < 3000; i++) begin
         resetn      = ($urandom_range(0, 99) != 0);
         inst_req    = ($urandom_range(0, 9) < 6);
         inst_addr   = $urandom();
         data_req    = ($urandom_range(0, 9) < 6);
         data_wr     = 1'($urandom_range(0, 1));
         data_wstrb  = 4'($urandom_range(0, 15));
         data_addr   = $urandom();
         data_wdata  = $urandom();
         mem_addr_ok = 1'($urandom_range(0, 1));
         mem_data_ok = 1'($urandom_range(0, 1));
         mem_rdata   = $urandom();
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_PRIO, default 1, meaning that when it is 1 the data port wins simultaneous requests and when it is 0 the two ports alternate round-robin.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 inst_req  input  1  fetch read request; held high with inst_addr stable until inst_addr_ok.
REQ-005 inst_addr  input  32  fetch byte address.
REQ-006 inst_addr_ok  output  1  one-cycle pulse: fetch request accepted by memory.
REQ-007 inst_data_ok  output  1  one-cycle pulse: inst_rdata valid.
REQ-008 inst_rdata  output  32  fetch read data.
REQ-009 data_req  input  1  load/store request; held high with its fields stable until data_addr_ok.
REQ-010 data_wr  input  1  1 = store, 0 = load.
REQ-011 data_wstrb  input  4  byte write enables; ignored on loads.
REQ-012 data_addr  input  32  load/store byte address.
REQ-013 data_wdata  input  32  store data.
REQ-014 data_addr_ok  output  1  one-cycle pulse: data request accepted.
REQ-015 data_data_ok  output  1  one-cycle pulse: load data valid, or store complete.
REQ-016 data_rdata  output  32  load data.
REQ-017 mem_req, mem_wr, mem_wstrb[3:0], mem_addr[32], mem_wdata[32]  outputs  shared memory request, driven from latched fields.
REQ-018 mem_addr_ok, mem_data_ok  inputs  1  memory accept and response pulses; mem_rdata  input  32  response data.
REQ-019 stallreq  output  1  pipeline stall request to the CTRL stall bus.

Function
REQ-020 The FSM SHALL have the states IDLE, I_ADDR, I_DATA, D_ADDR and D_DATA, with exactly one memory transaction outstanding at any time.
REQ-021 Grant rule: on a grant, the FSM SHALL move to x_ADDR and latch the granted port's wr, wstrb, addr and wdata; an inst grant SHALL force wr=0 and wstrb=0.
REQ-022 Arbitration with DATA_PRIO=1: data_req SHALL be granted over inst_req.
REQ-023 Arbitration with DATA_PRIO=0: on a tie, the port not recorded in the last_grant register SHALL win; last_grant SHALL update on every grant.
REQ-024 In the x_ADDR states, mem_req SHALL be 1 and the mem_* outputs SHALL equal the latched fields.
REQ-025 In x_ADDR, when mem_addr_ok=1, the block SHALL pulse the matching x_addr_ok in the same cycle and move to x_DATA next cycle.
REQ-026 In x_DATA, when mem_data_ok=1, the block SHALL pulse the matching x_data_ok in the same cycle and drive x_rdata = mem_rdata combinationally.
REQ-027 The block SHALL register mem_rdata into x_rdata, so x_rdata holds its value until that port's next data_ok.
REQ-028 Back-to-back: in the mem_data_ok cycle, the block SHALL arbitrate on the requests present in that cycle and go straight to x_ADDR, with no IDLE bubble; with no request pending it SHALL go to IDLE.
REQ-029 mem_data_ok arriving in IDLE or x_ADDR, and mem_addr_ok arriving outside x_ADDR, SHALL be ignored with no state change and no pulse.
REQ-030 A request deasserted before grant SHALL be dropped silently; a request deasserted after grant SHALL have no effect, because its fields are latched.
REQ-031 stallreq = (inst_req | data_req | state != IDLE) & ~(x_DATA & mem_data_ok & no request pending).
REQ-032 Latency: an uncontended request with mem_addr_ok=1 on its first cycle SHALL see its x_addr_ok 1 cycle after x_req rises.
REQ-033 Latency: x_data_ok SHALL occur in the same cycle as mem_data_ok.

Reset
REQ-034 While resetn=0, the block SHALL asynchronously force state=IDLE, last_grant=inst, all latched fields=0, both x_rdata=0, and all outputs=0.
REQ-035 Reset in any non-IDLE state SHALL abandon the transaction: no x_addr_ok or x_data_ok is issued for it, and a late mem_data_ok after reset release is ignored per REQ-029.
REQ-036 The first grant SHALL be possible in the first rising edge after resetn deasserts.

Verification
REQ-037 inst_req, inst_addr=0xBFC00000; mem_addr_ok on cycle 1; mem_data_ok with 0x3C080001 on cycle 3 -> inst_addr_ok pulse at cycle 1, inst_data_ok and inst_rdata=0x3C080001 at cycle 3, stallreq=1 for cycles 0-2 and 0 at cycle 3.
REQ-038 DATA_PRIO=1, inst_req and data_req (load, 0x80001000) rise together -> mem_addr=0x80001000 first; inst granted in the data_data_ok cycle; mem_addr=0xBFC00000 the next cycle.
REQ-039 DATA_PRIO=0, both requests held for 4 transactions -> grant order D, I, D, I.
REQ-040 Store data_wr=1, data_wstrb=0xF, data_addr=0x80001000, data_wdata=0xDEADBEEF -> mem_wr=1, mem_wstrb=0xF, mem_wdata=0xDEADBEEF, one data_data_ok pulse, and data_rdata unchanged.
REQ-041 resetn low for 1 cycle while in D_DATA, then mem_data_ok -> no data_data_ok, state IDLE, and all outputs 0.
